// File: rtl/alu_pkg.sv
// Shared definitions for the ALU datapath and the blocks that drive it.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_t;

  // Shift amount is taken from the low bits of operand B.
  localparam int SHAMT_W = 5;

endpackage

// File: rtl/alu.sv
// Shared combinational ALU: ADD/SUB/AND/OR/XOR/SLL/SRL/SLT with a zero flag.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_t          op,
  output logic [WIDTH-1:0] y,
  output logic             zero
);

  logic [SHAMT_W-1:0] shamt;
  logic               lt;

  assign shamt = b[SHAMT_W-1:0];
  assign lt    = $signed(a) < $signed(b);

  // Select the operation result; add/sub wrap naturally at WIDTH bits.
  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_SLL: y = a << shamt;
      ALU_SRL: y = a >> shamt;
      ALU_SLT: y = {{(WIDTH-1){1'b0}}, lt};
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] idx,
  output logic           any
);

  int j;

  // Walk the requests starting at ptr; the first hit wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int off = 0; off < N; off++) begin
      j = int'(ptr) + off;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between N_REQ requesters through a round-robin arbiter and a
// one-entry registered response buffer tagged with the requester index.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Producers hold valid and payload stable until ready; valid never
// depends on ready. req_ready is one-hot or zero and is forced low during rst.
// The buffer is EMPTY when rsp_valid=0 and FULL when rsp_valid=1; a FULL
// buffer can be drained and refilled on the same edge.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ),
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ*3-1:0]     req_op,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [WIDTH-1:0]       rsp_result,
  output logic                   rsp_zero,
  output logic [CNT_W-1:0]       op_count
);

  logic [N_REQ-1:0] gnt;
  logic [IDW-1:0]   gnt_idx;
  logic             gnt_any;
  logic             can_accept;
  logic             accept;

  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [2:0]       sel_op;
  logic [WIDTH-1:0] alu_y;
  logic             alu_zero;

  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;

  rr_arbiter #(
    .N   (N_REQ),
    .IDW (IDW)
  ) u_arb (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  assign can_accept = !rsp_valid_q || rsp_ready;
  assign accept     = can_accept && gnt_any && !rst;
  assign req_ready  = accept ? gnt : '0;

  // Route the granted requester's operands to the ALU.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        sel_a  = req_a[i*WIDTH +: WIDTH];
        sel_b  = req_b[i*WIDTH +: WIDTH];
        sel_op = req_op[i*3 +: 3];
      end
    end
  end

  alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a    (sel_a),
    .b    (sel_b),
    .op   (alu_op_t'(sel_op)),
    .y    (alu_y),
    .zero (alu_zero)
  );

  // Next-state: capture on accept, drain when consumed, otherwise hold.
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    op_count_d   = op_count_q;
    rr_ptr_d     = rr_ptr_q;
    if (accept) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = gnt_idx;
      rsp_result_d = alu_y;
      rsp_zero_d   = alu_zero;
      op_count_d   = op_count_q + CNT_W'(1);
      rr_ptr_d     = (gnt_idx == IDW'(N_REQ-1)) ? '0 : gnt_idx + IDW'(1);
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      op_count_q   <= '0;
      rr_ptr_q     <= '0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      op_count_q   <= op_count_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table of single requests plus
// hand-written round-robin, backpressure, reset and counter-wrap sequences.
module tb_alu_arbiter;

  localparam int W = 32;
  localparam int N = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   req_ready_w4;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N*3-1:0] req_op;
  logic           rsp_ready;
  logic           rsp_valid, rsp_valid_w4;
  logic [1:0]     rsp_id, rsp_id_w4;
  logic [W-1:0]   rsp_result, rsp_result_w4;
  logic           rsp_zero, rsp_zero_w4;
  logic [15:0]    op_count;
  logic [3:0]     op_count_w4;

  int n_cmp;
  int n_fail;
  int exp_cnt;

  typedef struct {
    int         idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] res;
    logic        zero;
  } vec_t;

  vec_t vecs[10];

  alu_arbiter #(.WIDTH(W), .N_REQ(N), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .op_count(op_count)
  );

  alu_arbiter #(.WIDTH(W), .N_REQ(N), .CNT_W(4)) dut_w4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_w4),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid_w4), .rsp_ready(rsp_ready), .rsp_id(rsp_id_w4),
    .rsp_result(rsp_result_w4), .rsp_zero(rsp_zero_w4), .op_count(op_count_w4)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op);
    req_a[idx*W +: W] = a;
    req_b[idx*W +: W] = b;
    req_op[idx*3 +: 3] = op;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    exp_cnt = 0;
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    rsp_ready = 1'b1;

    //               idx  a             b             op    res           zero
    vecs[0] = '{0, 32'd5,        32'd7,        3'd0, 32'd12,       1'b0};
    vecs[1] = '{1, 32'hFFFFFFFE, 32'd1,        3'd7, 32'd1,        1'b0};
    vecs[2] = '{1, 32'd1,        32'h00000024, 3'd5, 32'h10,       1'b0};
    vecs[3] = '{2, 32'd3,        32'd5,        3'd1, 32'hFFFFFFFE, 1'b0};
    vecs[4] = '{3, 32'h0000F0F0, 32'h0000FF00, 3'd2, 32'h0000F000, 1'b0};
    vecs[5] = '{0, 32'h00000F00, 32'h000000F0, 3'd3, 32'h00000FF0, 1'b0};
    vecs[6] = '{2, 32'h00001234, 32'h00001234, 3'd4, 32'd0,        1'b1};
    vecs[7] = '{3, 32'h80000000, 32'd31,       3'd6, 32'd1,        1'b0};
    vecs[8] = '{1, 32'hFFFFFFFF, 32'd1,        3'd0, 32'd0,        1'b1};
    vecs[9] = '{0, 32'd1,        32'hFFFFFFFE, 3'd7, 32'd0,        1'b1};

    // Reset state, with every requester valid during reset.
    step();
    req_valid = 4'b1111;
    #1;
    check("ready_in_rst", 32'(req_ready), 32'h0);
    step();
    check("rst_valid", 32'(rsp_valid), 32'h0);
    check("rst_id", 32'(rsp_id), 32'h0);
    check("rst_result", rsp_result, 32'h0);
    check("rst_zero", 32'(rsp_zero), 32'h0);
    check("rst_count", 32'(op_count), 32'h0);
    req_valid = '0;
    rst = 1'b0;
    #1;
    check("ready_idle", 32'(req_ready), 32'h0);

    // Single-request vector table.
    for (int v = 0; v < 10; v++) begin
      set_req(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].op);
      req_valid = 4'(1 << vecs[v].idx);
      #1;
      check($sformatf("vec%0d_ready", v), 32'(req_ready), 32'(1 << vecs[v].idx));
      step();
      exp_cnt++;
      check($sformatf("vec%0d_valid", v), 32'(rsp_valid), 32'h1);
      check($sformatf("vec%0d_result", v), rsp_result, vecs[v].res);
      check($sformatf("vec%0d_zero", v), 32'(rsp_zero), 32'(vecs[v].zero));
      check($sformatf("vec%0d_id", v), 32'(rsp_id), 32'(vecs[v].idx));
      check($sformatf("vec%0d_count", v), 32'(op_count), 32'(exp_cnt));
    end
    req_valid = '0;
    step();
    check("drain_valid", 32'(rsp_valid), 32'h0);

    // Round robin with all requesters valid.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 32'd9, 32'd9, 3'd1);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("rr%0d_ready", k), 32'(req_ready), 32'(1 << (k % N)));
      step();
      exp_cnt++;
      check($sformatf("rr%0d_id", k), 32'(rsp_id), 32'(k % N));
      check($sformatf("rr%0d_result", k), rsp_result, 32'h0);
      check($sformatf("rr%0d_zero", k), 32'(rsp_zero), 32'h1);
    end
    check("rr_count", 32'(op_count), 32'd5);
    req_valid = '0;
    step();

    // Backpressure: fill from requester 2, then stall with 4'b1011 valid.
    set_req(2, 32'hFFFFFFFF, 32'd1, 3'd0);
    req_valid = 4'b0100;
    #1;
    check("bp_fill_ready", 32'(req_ready), 32'h4);
    step();
    exp_cnt++;
    check("bp_fill_id", 32'(rsp_id), 32'd2);
    set_req(0, 32'd100, 32'd1, 3'd0);
    set_req(1, 32'd200, 32'd1, 3'd0);
    set_req(3, 32'd10, 32'd3, 3'd1);
    rsp_ready = 1'b0;
    req_valid = 4'b1011;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp%0d_ready", k), 32'(req_ready), 32'h0);
      step();
      check($sformatf("bp%0d_valid", k), 32'(rsp_valid), 32'h1);
      check($sformatf("bp%0d_result", k), rsp_result, 32'h0);
      check($sformatf("bp%0d_zero", k), 32'(rsp_zero), 32'h1);
      check($sformatf("bp%0d_id", k), 32'(rsp_id), 32'd2);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_refill_ready", 32'(req_ready), 32'h8);
    step();
    exp_cnt++;
    check("bp_refill_id", 32'(rsp_id), 32'd3);
    check("bp_refill_result", rsp_result, 32'd7);
    check("bp_refill_count", 32'(op_count), 32'(exp_cnt));

    // Reset while FULL with rsp_id=3 and the pointer back at 0.
    req_valid = 4'b1111;
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(req_ready), 32'h0);
    step();
    rst = 1'b0;
    exp_cnt = 0;
    check("mid_rst_valid", 32'(rsp_valid), 32'h0);
    check("mid_rst_count", 32'(op_count), 32'h0);
    #1;
    check("post_rst_ready", 32'(req_ready), 32'h1);
    step();
    check("post_rst_id", 32'(rsp_id), 32'd0);
    check("post_rst_result", rsp_result, 32'd101);
    check("post_rst_count", 32'(op_count), 32'd1);
    req_valid = '0;
    step();

    // Counter wrap: 17 accepts on the 4-bit counter instance.
    do_reset();
    req_valid = 4'b1111;
    for (int k = 0; k < 17; k++) begin
      step();
      if (k == 15) check("w4_count16", 32'(op_count_w4), 32'd0);
    end
    check("w4_count17", 32'(op_count_w4), 32'd1);
    check("w16_count17", 32'(op_count), 32'd17);
    req_valid = '0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one combinational alu datapath (the team's WIDTH-bit ADD/SUB/AND/OR/XOR/SLL/SRL/SLT unit with a zero flag) between N requesters.
- Round-robin arbitration picks at most one request per cycle.
- The granted operands are driven through the alu and the result is registered into a one-entry response buffer.
- Each response is tagged with the requester index.
- The block sits between the issue logic of several clients and the shared ALU, and gives each client a valid/ready handshake.

Parameters:
- WIDTH, 32: operand/result width; passed through to the alu instance.
- N_REQ, 4: number of requesters; legal range 2..16.
- IDW, $clog2(N_REQ): width of rsp_id; derived, do not override.
- CNT_W, 16: width of the accepted-operation counter.

Ports:
- clk, in, 1: single clock; all state updates on its rising edge.
- rst, in, 1: synchronous, active-high reset; sampled on the rising edge of clk.
- req_valid, in, N_REQ: per-requester request valid.
- req_ready, out, N_REQ: per-requester accept strobe; one-hot or zero.
- req_a, in, N_REQ*WIDTH: packed operand A; requester i owns bits [i*WIDTH +: WIDTH].
- req_b, in, N_REQ*WIDTH: packed operand B, same packing as req_a.
- req_op, in, N_REQ*3: packed 3-bit alu_op per requester.
- rsp_valid, out, 1: response buffer holds a result.
- rsp_ready, in, 1: consumer accepts the response.
- rsp_id, out, IDW: index of the requester that produced the response.
- rsp_result, out, WIDTH: registered ALU result.
- rsp_zero, out, 1: registered ALU zero flag.
- op_count, out, CNT_W: number of accepted requests since reset.

Behaviour:
- Reset values (synchronous rst=1 at an edge): rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, op_count=0, rr_ptr=0.
- While rst is high, req_ready=0 combinationally, and no request is accepted on that edge.
- Buffer state (2 states, encoded by rsp_valid):
  - EMPTY (rsp_valid=0): can_accept=1.
  - FULL (rsp_valid=1): can_accept=rsp_ready, i.e. drain and refill in the same cycle.
- Arbitration:
  - Search order is rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - grant = first i in that order with req_valid[i]=1.
  - req_ready[i] = can_accept & grant[i] & !rst.
  - req_ready is at most one-hot and is zero when no req_valid is set.
- Accept: a handshake is req_valid[g] & req_ready[g]. On that edge:
  - rsp_result <= alu(req_a[g], req_b[g], req_op[g]); rsp_zero <= zero flag; rsp_id <= g.
  - rsp_valid <= 1.
  - rr_ptr <= (g+1) mod N_REQ.
  - op_count <= op_count+1, wrapping modulo 2^CNT_W.
- No accept:
  - If FULL and rsp_ready=1, then rsp_valid <= 0.
  - Otherwise all state holds.
  - rr_ptr changes only on accept.
- Latency: exactly 1 cycle from accept edge to rsp_valid.
- Throughput: 1 op/cycle while rsp_ready is held high.
- Backpressure:
  - While rsp_valid & !rsp_ready, rsp_result, rsp_zero and rsp_id are stable and every req_ready is 0.
- Requester rules:
  - A requester must hold req_valid and its operands stable until it sees req_ready.
  - req_valid must not depend on req_ready.
- ALU semantics are unchanged from the shared datapath:
  - Shifts use b[4:0].
  - SLT is signed and yields 0 or 1.
  - Add and subtract wrap modulo 2^WIDTH.
- Fairness: with all requesters continuously valid and rsp_ready=1, grants rotate 0,1,..,N_REQ-1,0,...
- A requester that stays valid waits at most N_REQ-1 accepts by others.
- Reset mid-operation: a pending response is discarded (rsp_valid=0) and rr_ptr returns to 0. No partial state survives.

Decomposition:
- Shared package alu_pkg:
  - alu_op_t enum: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SLT=7.
  - SHAMT_W=5 constant.
  - Used by both the alu and this block.
- Sub-module rr_arbiter #(N): inputs req[N] and ptr; output one-hot gnt[N] plus encoded index. Purely combinational.
- The alu is instantiated once; alu_arbiter holds all sequential state.

Test Plan:
- Single request: rst then req_valid=4'b0001, a=5, b=7, op=ADD, rsp_ready=1 -> req_ready=0001 on the first cycle; next cycle rsp_valid=1, rsp_result=12, rsp_zero=0, rsp_id=0, op_count=1.
- Round-robin: req_valid=4'b1111 held, rsp_ready=1, each requester op=SUB with a=b=9 -> rsp_id sequence 0,1,2,3,0, all rsp_result=0 and rsp_zero=1; op_count=5 after 5 accepts.
- Backpressure: fill buffer from requester 2 (a=0xFFFFFFFF, b=1, ADD), then hold rsp_ready=0 for 3 cycles with req_valid=4'b1011 -> req_ready=0 throughout; rsp_result=0, rsp_zero=1, rsp_id=2 stable. Raise rsp_ready -> same-cycle refill grants requester 3 (rr_ptr=3).
- Signed SLT/shift: requester 1, a=0xFFFFFFFE, b=1, SLT -> rsp_result=1. Requester 1, a=1, b=0x00000024, SLL -> rsp_result=0x10, using shift amount 4.
- Reset mid-operation: buffer FULL with rsp_id=3 and rr_ptr=0; assert rst for 1 cycle with req_valid=4'b1111 -> no accept on that edge; then rsp_valid=0, op_count=0, and the next grant goes to requester 0.
- Counter wrap: CNT_W=4, 17 accepts -> op_count=1.
